// File: rtl/ff_pkg.sv
// ff_pkg: flip-flop mode encoding and single-bit next-state function shared by ff_bank
package ff_pkg;
  typedef enum logic [1:0] {FF_SR = 2'b00, FF_JK = 2'b01, FF_D = 2'b10, FF_T = 2'b11} ff_mode_e;
  function automatic logic ff_next(ff_mode_e mode, logic a, logic b, logic q);
    return mode == FF_D ? a :
           mode == FF_T ? a ^ q :
           (a && b)     ? (mode == FF_JK ? ~q : q) :
           a ? 1'b1 : b ? 1'b0 : q;
  endfunction
endpackage

// File: rtl/ff_cell.sv
// ff_cell: one channel (q, sticky err) of ff_bank; clk, rst_n, en, mode, a, b, clr_err in; q, err out
import ff_pkg::*;
module ff_cell #(
  parameter logic RST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  ff_mode_e   mode,
  input  logic       a,
  input  logic       b,
  input  logic       clr_err,
  output logic       q,
  output logic       err
);
  logic q_q, q_d, err_q, err_d;
  always_comb begin
    q_d   = en ? ff_next(mode, a, b, q_q) : q_q;
    err_d = clr_err ? 1'b0 : err_q | (en && mode == FF_SR && a && b);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q   <= RST;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end
  assign q   = q_q;
  assign err = err_q;
endmodule

// File: rtl/ff_bank.sv
// ff_bank: WIDTH SR/JK/D/T flip-flop channels with sticky illegal-SR flags; err_cnt exists only with FF_BANK_ERR_CNT_EN
import ff_pkg::*;
module ff_bank #(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] err,
`ifdef FF_BANK_ERR_CNT_EN
  output logic [CNT_W-1:0] err_cnt,
`endif
  output logic             err_any
);
  ff_mode_e mode_e;
  assign mode_e = ff_mode_e'(mode);
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(.RST(RST_VAL[i])) u_cell (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode_e), .a(a[i]), .b(b[i]),
      .clr_err(clr_err), .q(q[i]), .err(err[i])
    );
  end
  assign qb      = ~q;
  assign err_any = |err;
`ifdef FF_BANK_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             illegal;
  always_comb begin
    illegal   = en && mode_e == FF_SR && |(a & b);
    err_cnt_d = clr_err ? '0 : (illegal && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end
  assign err_cnt = err_cnt_q;
`endif
endmodule
